// File: rtl/multirate_v3_mul_pipe.sv
// Pipelined signed x {signed|unsigned} multiplier for the filterbank MAC datapath.
// It has a valid/ready elastic handshake, a clock enable, and a rounding-shift output stage that saturates or wraps.
module multirate_v3_mul_pipe #(
   parameter int DIN0_WIDTH  = 16,
   parameter int DIN1_WIDTH  = 10,
   parameter int DIN1_SIGNED = 0,
   parameter int DOUT_WIDTH  = 26,
   parameter int NUM_STAGE   = 3,
   parameter int SHIFT       = 0,
   parameter int SATURATE    = 1
) (
   input  logic                  ap_clk,
   input  logic                  ap_rst,
   input  logic                  ce,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DIN0_WIDTH-1:0] din0,
   input  logic [DIN1_WIDTH-1:0] din1,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DOUT_WIDTH-1:0] dout,
   output logic                  ovf
);

   localparam int P   = DIN0_WIDTH + DIN1_WIDTH;
   localparam int RW  = (P + 1 > DOUT_WIDTH) ? P + 1 : DOUT_WIDTH;
   localparam int RSH = (SHIFT > 0) ? SHIFT - 1 : 0;
   localparam logic signed [P:0]    RND  = (SHIFT > 0) ? ({{P{1'b0}}, 1'b1} << RSH) : '0;
   localparam logic signed [RW-1:0] MAXV = {{(RW-DOUT_WIDTH+1){1'b0}}, {(DOUT_WIDTH-1){1'b1}}};
   localparam logic signed [RW-1:0] MINV = {{(RW-DOUT_WIDTH+1){1'b1}}, {(DOUT_WIDTH-1){1'b0}}};

   if (NUM_STAGE < 1 || NUM_STAGE > 4) begin : g_bad_stage
      $error("multirate_v3_mul_pipe: NUM_STAGE=%0d outside 1..4", NUM_STAGE);
   end
   if (SHIFT < 0 || SHIFT >= P) begin : g_bad_shift
      $error("multirate_v3_mul_pipe: SHIFT=%0d outside 0..%0d", SHIFT, P - 1);
   end

   logic [NUM_STAGE-1:0]  vld;
   logic                  advance;
   logic                  last_vld;
   logic signed [P-1:0]   pfin;
   logic signed [P:0]     rsum;
   logic signed [P:0]     rshift;
   logic signed [RW-1:0]  rext;
   logic [DOUT_WIDTH-1:0] map_dout;
   logic                  map_ovf;

   // Both operands are widened to P bits. The exact product always fits in P bits, so a P-bit multiply is lossless.
   function automatic logic signed [P-1:0] mul(input logic [DIN0_WIDTH-1:0] a,
                                               input logic [DIN1_WIDTH-1:0] b);
      logic signed [P-1:0] ax;
      logic signed [P-1:0] bx;
      logic                bs;
      bs = (DIN1_SIGNED != 0) && b[DIN1_WIDTH-1];
      ax = {{(P-DIN0_WIDTH){a[DIN0_WIDTH-1]}}, a};
      bx = {{(P-DIN1_WIDTH){bs}}, b};
      return ax * bx;
   endfunction

   // A full output stage freezes the whole pipe. Bubbles are never squeezed out.
   assign advance   = ce & (~vld[NUM_STAGE-1] | out_ready);
   assign in_ready  = advance;
   assign out_valid = vld[NUM_STAGE-1];

   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         vld <= '0;
      end else if (advance) begin
         vld[0] <= in_valid;
         for (int i = 1; i < NUM_STAGE; i++) begin
            vld[i] <= vld[i-1];
         end
      end
   end

   if (NUM_STAGE == 1) begin : g_s1
      assign pfin     = mul(din0, din1);
      assign last_vld = in_valid;
   end else begin : g_sn
      logic [DIN0_WIDTH-1:0] a_q;
      logic [DIN1_WIDTH-1:0] b_q;

      always_ff @(posedge ap_clk) begin
         if (ap_rst) begin
            a_q <= '0;
            b_q <= '0;
         end else if (advance && in_valid) begin
            a_q <= din0;
            b_q <= din1;
         end
      end

      if (NUM_STAGE == 2) begin : g_s2
         assign pfin = mul(a_q, b_q);
      end else begin : g_s34
         logic signed [P-1:0] p_q [NUM_STAGE-2];

         // Each product register only loads when the slot behind it holds a real sample.
         always_ff @(posedge ap_clk) begin
            if (ap_rst) begin
               for (int i = 0; i < NUM_STAGE - 2; i++) begin
                  p_q[i] <= '0;
               end
            end else if (advance) begin
               if (vld[0]) begin
                  p_q[0] <= mul(a_q, b_q);
               end
               for (int i = 1; i < NUM_STAGE - 2; i++) begin
                  if (vld[i]) begin
                     p_q[i] <= p_q[i-1];
                  end
               end
            end
         end

         assign pfin = p_q[NUM_STAGE-3];
      end

      assign last_vld = vld[NUM_STAGE-2];
   end

   // The rounding add needs P+1 bits so the most positive product plus the half-LSB cannot overflow.
   always_comb begin
      rsum     = {pfin[P-1], pfin} + RND;
      rshift   = rsum >>> SHIFT;
      rext     = RW'(rshift);
      map_ovf  = (rext > MAXV) || (rext < MINV);
      map_dout = rext[DOUT_WIDTH-1:0];
      if (map_ovf && SATURATE != 0) begin
         map_dout = (rext > MAXV) ? MAXV[DOUT_WIDTH-1:0] : MINV[DOUT_WIDTH-1:0];
      end
   end

   // dout and ovf only load when a valid sample enters the last stage, so they hold steady across bubbles.
   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         dout <= '0;
         ovf  <= 1'b0;
      end else if (advance && last_vld) begin
         dout <= map_dout;
         ovf  <= map_ovf;
      end
   end

endmodule

// File: tb/tb_multirate_v3_mul_pipe.sv
// Self-checking bench. Several parameter corners of multirate_v3_mul_pipe share one stimulus stream.
// Each instance is compared against a queue-based reference model that tracks per-sample pipeline age.
module tb_multirate_v3_mul_pipe;

   localparam int NDUT = 8;
   localparam int CNS  [NDUT] = '{3, 1, 2, 4, 3, 1, 2, 4};
   localparam int CS1  [NDUT] = '{0, 1, 0, 1, 1, 0, 1, 0};
   localparam int CDW  [NDUT] = '{26, 16, 16, 20, 12, 30, 26, 16};
   localparam int CSH  [NDUT] = '{0, 4, 0, 4, 0, 2, 1, 0};
   localparam int CSAT [NDUT] = '{1, 1, 1, 0, 0, 1, 1, 0};

   logic        ap_clk = 1'b0;
   logic        ap_rst;
   logic        ce;
   logic        in_valid;
   logic        out_ready;
   logic [15:0] din0;
   logic [9:0]  din1;

   wire               irdy [NDUT];
   wire               ovld [NDUT];
   wire               ovfl [NDUT];
   wire signed [63:0] dval [NDUT];

   always #5 ap_clk = ~ap_clk;

   for (genvar k = 0; k < NDUT; k++) begin : g_dut
      logic [CDW[k]-1:0] d;
      multirate_v3_mul_pipe #(
         .DIN0_WIDTH (16),
         .DIN1_WIDTH (10),
         .DIN1_SIGNED(CS1[k]),
         .DOUT_WIDTH (CDW[k]),
         .NUM_STAGE  (CNS[k]),
         .SHIFT      (CSH[k]),
         .SATURATE   (CSAT[k])
      ) u_dut (
         .ap_clk   (ap_clk),
         .ap_rst   (ap_rst),
         .ce       (ce),
         .in_valid (in_valid),
         .in_ready (irdy[k]),
         .din0     (din0),
         .din1     (din1),
         .out_valid(ovld[k]),
         .out_ready(out_ready),
         .dout     (d),
         .ovf      (ovfl[k])
      );
      assign dval[k] = 64'($signed(d));
   end

   typedef struct {
      longint val;
      bit     ov;
      longint stamp;
   } entry_t;

   entry_t pipeq    [NDUT][$];
   longint advCnt   [NDUT];
   longint lastDout [NDUT];
   bit     lastOvf  [NDUT];
   int     testsRun    = 0;
   int     testsFailed = 0;

   task automatic checkOutput(input string tag, input logic signed [63:0] observed,
                              input logic signed [63:0] expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   // Plain-arithmetic result of one sample: exact product, round half up, shift, then clamp or wrap.
   function automatic void refModel(input int k, input logic [15:0] a, input logic [9:0] b,
                                    output longint val, output bit ov);
      longint av, bv, r, maxv, minv, w;
      av   = longint'($signed(a));
      bv   = (CS1[k] != 0) ? longint'($signed(b)) : longint'(b);
      r    = av * bv;
      if (CSH[k] > 0) r = r + (longint'(1) <<< (CSH[k] - 1));
      r    = r >>> CSH[k];
      maxv = (longint'(1) <<< (CDW[k] - 1)) - 1;
      minv = -maxv - 1;
      w    = r & ((longint'(1) <<< CDW[k]) - 1);
      if (w > maxv) w = w - (longint'(1) <<< CDW[k]);
      ov   = (r > maxv) || (r < minv);
      val  = !ov ? r : (CSAT[k] != 0) ? ((r > maxv) ? maxv : minv) : w;
   endfunction

   function automatic bit expValid(input int k);
      if (pipeq[k].size() == 0) return 1'b0;
      return (advCnt[k] - pipeq[k][0].stamp + 1) == longint'(CNS[k]);
   endfunction

   // Called at a falling edge. It checks the visible state, drives one cycle of inputs, and advances the model across the next rising edge.
   task automatic applyStimulus(input bit r, input bit c, input bit iv, input logic [15:0] a,
                                input logic [9:0] b, input bit ordy);
      bit     ev, adv;
      longint v;
      bit     o;
      for (int k = 0; k < NDUT; k++) begin
         ev = expValid(k);
         checkOutput($sformatf("out_valid[%0d]", k), ovld[k], ev);
         checkOutput($sformatf("dout[%0d]", k), dval[k], lastDout[k]);
         if (ev) checkOutput($sformatf("ovf[%0d]", k), ovfl[k], lastOvf[k]);
      end
      ap_rst = r; ce = c; in_valid = iv; din0 = a; din1 = b; out_ready = ordy;
      #1;
      for (int k = 0; k < NDUT; k++) begin
         ev  = expValid(k);
         adv = c && (!ev || ordy);
         checkOutput($sformatf("in_ready[%0d]", k), irdy[k], adv);
         if (r) begin
            pipeq[k].delete();
            lastDout[k] = 0;
            lastOvf[k]  = 1'b0;
         end else if (adv) begin
            if (ev) void'(pipeq[k].pop_front());
            advCnt[k]++;
            if (iv) begin
               refModel(k, a, b, v, o);
               pipeq[k].push_back('{val: v, ov: o, stamp: advCnt[k]});
            end
            if (expValid(k)) begin
               lastDout[k] = pipeq[k][0].val;
               lastOvf[k]  = pipeq[k][0].ov;
            end
         end
      end
      @(negedge ap_clk);
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b1, 1'b0, 16'd0, 10'd0, 1'b1);
   endtask

   logic [15:0] t3a [4] = '{16'd3, 16'hFFFD, 16'd3, 16'hFFF8};
   logic [9:0]  t3b [4] = '{10'd3, 10'd3, 10'd5, 10'd1};
   longint      t3e [4] = '{1, -1, 1, 0};

   initial begin
      logic [15:0] ra;
      logic [9:0]  rb;
      for (int k = 0; k < NDUT; k++) begin
         advCnt[k] = 0; lastDout[k] = 0; lastOvf[k] = 1'b0;
      end
      ap_rst = 1'b1; ce = 1'b1; in_valid = 1'b0; din0 = '0; din1 = '0; out_ready = 1'b1;
      repeat (3) @(negedge ap_clk);
      idleCycles(1);
      checkOutput("rst_out_valid", ovld[0], 1'b0);
      checkOutput("rst_dout", dval[0], 0);

      // Most negative din0 times the largest unsigned din1, visible exactly NUM_STAGE cycles later.
      applyStimulus(1'b0, 1'b1, 1'b1, 16'h8000, 10'd1023, 1'b1);
      idleCycles(2);
      checkOutput("t1_out_valid", ovld[0], 1'b1);
      checkOutput("t1_dout", dval[0], -33521664);
      checkOutput("t1_ovf", ovfl[0], 1'b0);
      idleCycles(2);

      applyStimulus(1'b0, 1'b1, 1'b1, 16'd1000, 10'd1000, 1'b1);
      idleCycles(1);
      checkOutput("t2_sat_dout", dval[2], 32767);
      checkOutput("t2_sat_ovf", ovfl[2], 1'b1);
      idleCycles(2);
      checkOutput("t2_wrap_dout", dval[7], 16960);
      checkOutput("t2_wrap_ovf", ovfl[7], 1'b1);
      idleCycles(1);

      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0, 1'b1, 1'b1, t3a[i], t3b[i], 1'b1);
         checkOutput($sformatf("t3_round_n1_%0d", i), dval[1], t3e[i]);
         idleCycles(3);
         checkOutput($sformatf("t3_round_n4_%0d", i), dval[3], t3e[i]);
      end

      // Back-to-back stream with a five-cycle downstream stall in the middle.
      for (int i = 0; i < 15; i++) begin
         applyStimulus(1'b0, 1'b1, 1'b1, 16'($urandom), 10'($urandom), !(i >= 5 && i < 10));
         if (i >= 5 && i < 10) checkOutput("t4_stall_in_ready", irdy[0], 1'b0);
      end
      idleCycles(5);

      // Reset with samples in flight must drop them all.
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b1, 16'd1234 + 16'(i), 10'd77, 1'b1);
      applyStimulus(1'b1, 1'b1, 1'b1, 16'd999, 10'd3, 1'b1);
      checkOutput("t5_out_valid", ovld[0], 1'b0);
      checkOutput("t5_dout", dval[0], 0);
      applyStimulus(1'b0, 1'b1, 1'b1, 16'd100, 10'd7, 1'b1);
      idleCycles(2);
      checkOutput("t5_new_valid", ovld[0], 1'b1);
      checkOutput("t5_new_dout", dval[0], 700);
      idleCycles(2);

      for (int i = 0; i < 10000; i++) begin
         case ($urandom_range(0, 7))
            0:       ra = 16'h8000;
            1:       ra = 16'h7FFF;
            default: ra = 16'($urandom);
         endcase
         case ($urandom_range(0, 7))
            0:       rb = 10'h200;
            1:       rb = 10'h3FF;
            default: rb = 10'($urandom);
         endcase
         applyStimulus($urandom_range(0, 999) == 0, $urandom_range(0, 3) != 0,
                       $urandom_range(0, 1) != 0, ra, rb, $urandom_range(0, 3) != 0);
      end
      idleCycles(6);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
